alu_rr_sched: RTL
=================

// Module: alu_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one 4-bit pipelined ALU (operand regs + output reg) among NUM_REQ requesters.
//  Sequences the ALU load/output enables, returns each result with the requester ID over a valid/ready channel.
//  Sits between client blocks and the ALU; only this block drives ALU enables, op select and operands.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  DW       4   operand/result width; must match ALU width
//  IDW      $clog2(NUM_REQ)  requester ID width (derived, not overridable)
// PORTS
//  clk            in   1            single clock, rising edge
//  rst            in   1            asynchronous, active-high reset
//  req_valid      in   NUM_REQ      per-requester request valid
//  req_ready      out  NUM_REQ      per-requester accept; at most one bit high
//  req_a          in   NUM_REQ*DW   operand A, requester i at [i*DW +: DW]
//  req_b          in   NUM_REQ*DW   operand B, same packing
//  req_op         in   NUM_REQ*2    op: 00 ADD, 01 AND, 10 OR, 11 NAND
//  rsp_valid      out  1            result valid
//  rsp_ready      in   1            result consumer ready
//  rsp_data       out  DW           ALU result
//  rsp_id         out  IDW          requester index of rsp_data
//  alu_en_i       out  1            ALU operand-load enable
//  alu_en_o       out  1            ALU output-register enable
//  alu_select_op  out  2            ALU op select
//  alu_a, alu_b   out  DW each      ALU operands
//  alu_out        in   DW           ALU registered result
//  busy           out  1            high in any state except IDLE
// BEHAVIOUR
//  Reset (async, active-high): state IDLE, RR pointer 0, all outputs 0 (req_ready, rsp_*, alu_*, busy).
//  FSM: IDLE -> LOAD -> EXEC -> CAPT -> RESP -> IDLE.
//   IDLE: if any req_valid, grant g = first valid index at/after pointer (wrapping); req_ready[g]=1 (comb);
//         at edge latch req_a/b/op[g] into alu_a/alu_b/alu_select_op, g into rsp_id; pointer <= (g+1)%NUM_REQ; -> LOAD.
//   LOAD: alu_en_i=1 one cycle (ALU captures operands at edge); -> EXEC.
//   EXEC: alu_en_o=1 one cycle (ALU result register loads at edge); -> CAPT.
//   CAPT: rsp_data <= alu_out at edge; rsp_valid <= 1; -> RESP.
//   RESP: hold rsp_valid/rsp_data/rsp_id stable until rsp_ready; on rsp_valid&rsp_ready: rsp_valid <= 0; -> IDLE.
//  alu_en_i/alu_en_o are 0 outside LOAD/EXEC; alu_select_op/alu_a/alu_b held constant LOAD..CAPT (ALU op decode is combinational).
//  alu_out is sampled only in CAPT; the ALU output register reads 0 whenever alu_en_o was low.
//  Latency: accept edge E0 -> rsp_valid high after E3; min 5 cycles/op (IDLE..RESP).
//  Arithmetic: ADD wraps mod 2^DW; no carry out.
//  req_ready low in every state but IDLE; req_valid may drop without penalty while not granted.
//  Sole requester repeats are granted every op; pointer skips non-valid indices.
//  rsp_ready high with rsp_valid low: ignored. Backpressure stalls in RESP indefinitely; no request is accepted.
//  Reset mid-operation: in-flight request and result are discarded, no response produced; ALU internal regs are not cleared but are not observed until the next CAPT.
// CONFIGURATION
//  ALU_SCHED_B2B_EN defined: in RESP, when rsp_ready=1 and any req_valid=1, grant as in IDLE in the same cycle
//   (req_ready[g]=1, latch operands, rsp_valid <= 0, -> LOAD); throughput 4 cycles/op.
//  ALU_SCHED_B2B_EN undefined: RESP always returns to IDLE; req_ready never asserted in RESP; 5 cycles/op.
// TESTING
//  Single op: req_valid=0001, a=3, b=5, op=00 -> req_ready=0001 one cycle; rsp_valid 3 cycles later, rsp_data=8, rsp_id=0.
//  All four ops on requester 2, a=4'hC, b=4'hA -> rsp_data 6 (wrap), 8, E, 7 in order, rsp_id=2 each.
//  Fairness: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; no requester granted twice in a row.
//  Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid/data/id stable, req_ready=0, alu_en_i/alu_en_o=0 throughout.
//  Reset in EXEC: rst pulse -> all outputs 0 immediately, no rsp_valid; next request from requester 1 gets rsp_id=1 with correct result.
//  B2B (macro defined): req_valid=0011, rsp_ready=1 -> consecutive rsp_valid pulses 4 cycles apart; undefined -> 5 cycles apart.

Source files
------------

// File: rtl/alu_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_rr_sched                                                 |
// | Description : Round-robin scheduler that time-shares one pipelined 4-bit   |
// |               ALU among NUM_REQ requesters. It sequences the ALU operand   |
// |               and output enables, then returns each result tagged with the |
// |               requester ID over a valid/ready channel.                     |
// |               Optional macro ALU_SCHED_B2B_EN: grant the next request in   |
// |               the RESP cycle so operations run back to back (4 cycles/op). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 4,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*DW-1:0] req_a,
   input  logic [NUM_REQ*DW-1:0] req_b,
   input  logic [NUM_REQ*2-1:0]  req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DW-1:0]         rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic                  alu_en_i,
   output logic                  alu_en_o,
   output logic [1:0]            alu_select_op,
   output logic [DW-1:0]         alu_a,
   output logic [DW-1:0]         alu_b,
   input  logic [DW-1:0]         alu_out,
   output logic                  busy
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_EXEC = 3'd2;
   localparam logic [2:0] S_CAPT = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [2:0]     state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] grant_idx;
   logic           grant_found;
   logic           accept;
   int             cand;

   // Pick the first valid requester at or after the pointer, wrapping around.
   // Scanning from the farthest offset down lets the nearest one win.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

`ifdef ALU_SCHED_B2B_EN
   // A new grant may overlap the response handshake of the previous op.
   assign accept = grant_found &&
                   ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
`else
   assign accept = grant_found && (state == S_IDLE);
`endif

   assign req_ready = accept ? (ONE_HOT_0 << grant_idx) : '0;
   assign alu_en_i  = (state == S_LOAD);
   assign alu_en_o  = (state == S_EXEC);
   assign busy      = (state != S_IDLE);

   // Sequence the ALU pipeline, capture the result and hold it until taken;
   // latch the granted operands and advance the pointer on every accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         ptr           <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_id        <= '0;
         alu_select_op <= 2'b00;
         alu_a         <= '0;
         alu_b         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: state <= S_EXEC;
            S_EXEC: state <= S_CAPT;
            S_CAPT: begin
               rsp_data  <= alu_out;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= accept ? S_LOAD : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (accept) begin
            alu_a         <= req_a[int'(grant_idx)*DW +: DW];
            alu_b         <= req_b[int'(grant_idx)*DW +: DW];
            alu_select_op <= req_op[int'(grant_idx)*2 +: 2];
            rsp_id        <= grant_idx;
            if (grant_idx == IDW'(NUM_REQ - 1)) begin
               ptr <= '0;
            end else begin
               ptr <= grant_idx + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
